// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, ALU and response buses around alu_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the environment: requesters, the ALU and the response consumer.
interface alu_arbiter_if #(
  parameter int W = 16
);
  logic         req0_valid;
  logic         req0_ready;
  logic [4:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [4:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic [4:0]   alu_op;
  logic [W-1:0] alu_operandA;
  logic [W-1:0] alu_operandB;
  logic [W-1:0] alu_result;
  logic [3:0]   alu_flags;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [W-1:0] resp_result;
  logic [3:0]   resp_flags;
  logic         busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_operandA, alu_operandB,
    input  alu_result, alu_flags,
    output resp_valid, resp_id, resp_result, resp_flags,
    input  resp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_operandA, alu_operandB,
    output alu_result, alu_flags,
    input  resp_valid, resp_id, resp_result, resp_flags,
    output resp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two
// requesters. At most one op is in flight. The op is latched in IDLE, held on
// the ALU for one EXEC cycle, and the result is registered. The result is then
// presented in RESP until the consumer takes it.
module alu_arbiter #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic                last_grant;

  // Stage 0: op latched at grant and held on the ALU inputs
  logic [4:0]          op_p0;
  logic signed [W-1:0] a_p0;
  logic signed [W-1:0] b_p0;
  logic                id_p0;

  // Stage 1: registered ALU response
  logic                vld_p1;
  logic                id_p1;
  logic signed [W-1:0] result_p1;
  logic [3:0]          flags_p1;

  logic                win_vld;
  logic                win_id;

  // Pick the winner in IDLE. When both requesters are valid, the one not granted last time wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        win_vld = 1'b1;
        win_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        win_vld = 1'b1;
      end else if (bus.req1_valid) begin
        win_vld = 1'b1;
        win_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready   = win_vld & ~win_id;
  assign bus.req1_ready   = win_vld &  win_id;

  assign bus.alu_op       = op_p0;
  assign bus.alu_operandA = a_p0;
  assign bus.alu_operandB = b_p0;

  assign bus.resp_valid   = vld_p1;
  assign bus.resp_id      = id_p1;
  assign bus.resp_result  = result_p1;
  assign bus.resp_flags   = flags_p1;
  assign bus.busy         = (state != IDLE);

  // Control FSM: grant, execute for one cycle, then hold the response until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_p0      <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      id_p0      <= 1'b0;
      vld_p1     <= 1'b0;
      id_p1      <= 1'b0;
      result_p1  <= '0;
      flags_p1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            op_p0      <= win_id ? bus.req1_op : bus.req0_op;
            a_p0       <= signed'(win_id ? bus.req1_a : bus.req0_a);
            b_p0       <= signed'(win_id ? bus.req1_b : bus.req0_b);
            id_p0      <= win_id;
            last_grant <= win_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_p1 <= signed'(bus.alu_result);
          flags_p1  <= bus.alu_flags;
          id_p1     <= id_p0;
          vld_p1    <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A small behavioural ALU closes the
// loop, and every expected value below is a hand-computed constant.
module tb_alu_arbiter;

  localparam int W = 16;
  localparam logic [4:0] OP_AND = 5'b01010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.W(W)) bus ();

  alu_arbiter #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU: AND and ADD; flags = {negative, zero, 0, 0}
  always_comb begin
    case (bus.alu_op)
      5'b01010: bus.alu_result = bus.alu_operandA & bus.alu_operandB;
      5'b00000: bus.alu_result = bus.alu_operandA + bus.alu_operandB;
      default:  bus.alu_result = '0;
    endcase
    bus.alu_flags = {bus.alu_result[W-1], (bus.alu_result == '0), 2'b00};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
    bus.req1_valid = 1'b0; bus.req1_op = '0;     bus.req1_a = '0;       bus.req1_b = '0;
    bus.resp_ready = 1'b0;

    // Reset state, with req0 already valid so that ready gating is checked
    tick(); tick();
    chk("rst_r0rdy", bus.req0_ready, 0);
    chk("rst_rvalid", bus.resp_valid, 0);
    chk("rst_rid", bus.resp_id, 0);
    chk("rst_result", bus.resp_result, 0);
    chk("rst_flags", bus.resp_flags, 0);
    chk("rst_aluop", bus.alu_op, 0);
    chk("rst_opA", bus.alu_operandA, 0);
    chk("rst_busy", bus.busy, 0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // T1: req0 AND -32 & 5 = 0
    bus.req0_valid = 1'b1; bus.req0_a = 16'hFFE0; bus.req0_b = 16'h0005; bus.resp_ready = 1'b1;
    #1;
    chk("t1_r0rdy", bus.req0_ready, 1);
    chk("t1_r1rdy", bus.req1_ready, 0);
    chk("t1_busy_idle", bus.busy, 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t1_r0rdy_exec", bus.req0_ready, 0);
    chk("t1_busy_exec", bus.busy, 1);
    chk("t1_rvalid_exec", bus.resp_valid, 0);
    chk("t1_aluop", bus.alu_op, 5'b01010);
    chk("t1_opA", bus.alu_operandA, 16'hFFE0);
    chk("t1_opB", bus.alu_operandB, 16'h0005);
    tick();
    chk("t1_rvalid", bus.resp_valid, 1);
    chk("t1_rid", bus.resp_id, 0);
    chk("t1_result", bus.resp_result, 16'h0000);
    chk("t1_flags", bus.resp_flags, 4'b0100);
    tick();
    chk("t1_rvalid_done", bus.resp_valid, 0);
    chk("t1_busy_done", bus.busy, 0);

    // T2: req1 AND -13 & -3 = -15
    bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_a = 16'hFFF3; bus.req1_b = 16'hFFFD;
    #1;
    chk("t2_r1rdy", bus.req1_ready, 1);
    chk("t2_r0rdy", bus.req0_ready, 0);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("t2_opA_exec", bus.alu_operandA, 16'hFFF3);
    chk("t2_opB_exec", bus.alu_operandB, 16'hFFFD);
    tick();
    chk("t2_rvalid", bus.resp_valid, 1);
    chk("t2_rid", bus.resp_id, 1);
    chk("t2_result", bus.resp_result, 16'hFFF1);
    chk("t2_flags", bus.resp_flags, 4'b1000);
    tick();

    // T3: both continuously valid; grants alternate 0,1,0
    bus.req0_valid = 1'b1; bus.req0_a = 16'd16; bus.req0_b = 16'd11;
    bus.req1_valid = 1'b1; bus.req1_a = 16'd16; bus.req1_b = 16'hFFF6;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("t3_r0rdy", bus.req0_ready, (g % 2 == 0) ? 1 : 0);
      chk("t3_r1rdy", bus.req1_ready, (g % 2 == 1) ? 1 : 0);
      tick();
      chk("t3_rdy_exec", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
      chk("t3_rdy_resp", {bus.req0_ready, bus.req1_ready}, 0);
      chk("t3_rid", bus.resp_id, g % 2);
      chk("t3_result", bus.resp_result, (g % 2 == 1) ? 16'd16 : 16'd0);
      tick();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // T4: backpressure while req1 waits
    bus.req0_valid = 1'b1; bus.req0_a = 16'd9; bus.req0_b = 16'd0; bus.resp_ready = 1'b0;
    #1;
    chk("t4_r0rdy", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'd7; bus.req1_b = 16'hFFFF;
    #1;
    chk("t4_r1rdy_exec", bus.req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_rvalid_hold", bus.resp_valid, 1);
      chk("t4_result_hold", bus.resp_result, 0);
      chk("t4_r1rdy_hold", bus.req1_ready, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("t4_rvalid_hs", bus.resp_valid, 1);
    chk("t4_r1rdy_hs", bus.req1_ready, 0);
    tick();
    chk("t4_rvalid_after", bus.resp_valid, 0);
    chk("t4_r1rdy_after", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("t4_rid", bus.resp_id, 1);
    chk("t4_result", bus.resp_result, 16'd7);
    chk("t4_flags", bus.resp_flags, 4'b0000);
    tick();

    // T5: reset asserted during EXEC discards the op
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h00FF;
    #1;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("t5_busy_exec", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_busy_rst", bus.busy, 0);
    chk("t5_rvalid_rst", bus.resp_valid, 0);
    chk("t5_opA_rst", bus.alu_operandA, 0);
    tick(); tick();
    chk("t5_rvalid_inrst", bus.resp_valid, 0);
    rst = 1'b0;
    tick();
    chk("t5_rvalid_post", bus.resp_valid, 0);
    chk("t5_busy_post", bus.busy, 0);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0F0F;
    #1;
    chk("t5_r0rdy", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("t5_rvalid", bus.resp_valid, 1);
    chk("t5_rid", bus.resp_id, 0);
    chk("t5_result", bus.resp_result, 16'h000F);
    tick();

    // T6: idle; ALU operands retain the last op
    for (int i = 0; i < 10; i++) begin
      chk("t6_rdy", {bus.req0_ready, bus.req1_ready}, 0);
      chk("t6_rvalid", bus.resp_valid, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_opA", bus.alu_operandA, 16'h00FF);
      chk("t6_opB", bus.alu_operandB, 16'h0F0F);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
